fp_norm_round: RTL and testbench
================================

FP_NORM_ROUND -- requirements
Module: fp_norm_round

Interface
REQ-001 SHALL have ports: clk  in  1  rising-edge clock; rst_n  in  1  asynchronous active-low reset.
REQ-002 SHALL have ports: in_valid  in  1  operand valid; in_ready  out  1  high only in IDLE.
REQ-003 SHALL have ports: in_sign  in  1; in_exp  in  8  larger biased exponent; in_mant  in  24  mantissa-ALU result; in_carry  in  1  mantissa-ALU carry-out.
REQ-004 SHALL have ports: in_g, in_r, in_s  in  1 each  guard/round/sticky bits from the aligner.
REQ-005 SHALL have ports: out_valid  out  1; out_ready  in  1; out_sign  out  1; out_exp  out  8; out_frac  out  23.
REQ-006 SHALL have ports: flag_nx  out  1  inexact; flag_of  out  1  overflow; flag_uf  out  1  subnormal and inexact.

Function
REQ-007 SHALL implement the FSM states IDLE, NORM, ROUND and DONE, with one state per clock.
REQ-008 Acceptance SHALL occur on an edge with state IDLE and in_valid=1. All inputs are latched; the exponent is held in a 9-bit working register.
REQ-009 Carry on acceptance: mant={1,in_mant[23:1]}, exp+1, g=in_mant[0], r=in_g, s=in_r|in_s.
REQ-010 An acceptance with in_carry=0 and in_mant=0 SHALL go directly to DONE with +0 (sign 0, exp 0, frac 0, all flags 0).
REQ-011 Any other acceptance SHALL go to NORM.
REQ-012 NORM with mant[23]=0 and exp>1 SHALL, per cycle: shift mant left 1, mant[0]=g, g=r, r=0, s unchanged, exp-1.
REQ-013 NORM with mant[23]=1 SHALL go to ROUND.
REQ-014 NORM with mant[23]=0 and exp=1 SHALL go to ROUND with the subnormal marker set; the encoded exponent becomes 0.
REQ-015 ROUND SHALL apply round-to-nearest-even: inc = g & (r | s | mant[0]).
REQ-016 If mant+inc overflows 24 bits, the mantissa SHALL become 0x800000 and exp SHALL become exp+1.
REQ-017 If a subnormal rounds up to bit 23 set, the encoded exponent SHALL become 1.
REQ-018 In ROUND: flag_nx=g|r|s; flag_uf=subnormal&flag_nx.
REQ-019 If final exp>=255, the result SHALL be exp=255, frac=0, flag_of=1, flag_nx=1.
REQ-020 ROUND SHALL go to DONE. Outputs SHALL be registered.
REQ-021 DONE SHALL assert out_valid. Outputs SHALL hold stable while out_ready=0.
REQ-022 out_valid&out_ready SHALL return the FSM to IDLE on the next edge. in_ready SHALL NOT be asserted in the same cycle as out_valid.
REQ-023 Latency SHALL be 3+N cycles from the acceptance edge to out_valid, where N is the number of NORM shifts; N<=23.
REQ-024 Latency for a zero result SHALL be 1 cycle.

Reset
REQ-025 rst_n=0 SHALL immediately force IDLE and clear all outputs and flags to 0; in_ready=1 once in IDLE.
REQ-026 Reset mid-NORM/ROUND/DONE SHALL discard the operation with no out_valid pulse.

Structure
REQ-027 A shared package/include SHALL hold: FSM state encodings, MANT_W=24, EXP_W=8, EXP_MAX=255, BIAS=127.
REQ-028 RNE increment and mantissa overflow SHALL live in a combinational sub-module fp_round_rne (inputs mant, g, r, s; outputs mant_rnd, mant_ovf, inexact).
REQ-029 Target size SHALL be 150-300 lines of RTL.

Verification
REQ-030 Carry (3.0) case: exp=127, carry=1, mant=0x800000, GRS=000 -> exp=128, frac=0x400000, nx=0, out_valid 3 cycles after acceptance.
REQ-031 Cancellation case: exp=127, carry=0, mant=0x000001, GRS=000 -> 23 shifts, exp=104, frac=0, out_valid 26 cycles after acceptance.
REQ-032 Ties case: mant=0x800001, GRS=100 -> frac=0x000002, nx=1; mant=0x800000, GRS=100 -> frac=0, nx=1.
REQ-033 Round and exponent overflow: mant=0xFFFFFF, exp=127, GRS=110 -> exp=128, frac=0; exp=254, carry=1 -> exp=255, frac=0, of=1, nx=1.
REQ-034 Zero and subnormal: carry=0, mant=0 -> +0 one cycle after acceptance; exp=2, mant=0x200000 -> 1 shift, exp=0, frac=0x400000, uf=0.
REQ-035 Handshake and reset: out_ready=0 for 5 cycles -> outputs constant, in_ready=0; rst_n pulse mid-NORM -> out_valid=0, in_ready=1, next operand processed correctly.

Source files
------------

// File: rtl/fp_norm_round_pkg.sv
// Shared constants, FSM encoding and result record for the FP normalize/round stage.
package fp_norm_round_pkg;

  localparam int MANT_W  = 24;
  localparam int EXP_W   = 8;
  localparam int EXP_MAX = 255;
  localparam int BIAS    = 127;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_NORM  = 2'd1,
    ST_ROUND = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  typedef struct packed {
    logic              sign;
    logic [EXP_W-1:0]  exp;
    logic [MANT_W-2:0] frac;
    logic              nx;
    logic              of;
    logic              uf;
  } res_t;

endpackage

// File: rtl/fp_round_rne.sv
// Round-to-nearest-even increment on a 24-bit significand with G/R/S, plus carry-out detect.
module fp_round_rne
  import fp_norm_round_pkg::*;
(
  input  logic [MANT_W-1:0] mant,
  input  logic              g,
  input  logic              r,
  input  logic              s,
  output logic [MANT_W-1:0] mant_rnd,
  output logic              mant_ovf,
  output logic              inexact
);

  logic            w_inc;
  logic [MANT_W:0] w_sum;

  assign w_inc    = g & (r | s | mant[0]);
  assign w_sum    = {1'b0, mant} + {{MANT_W{1'b0}}, w_inc};
  assign mant_ovf = w_sum[MANT_W];
  // 0xFFFFFF + 1 renormalizes to 1.000...; the exponent bump is the caller's job
  assign mant_rnd = mant_ovf ? {1'b1, {(MANT_W-1){1'b0}}} : w_sum[MANT_W-1:0];
  assign inexact  = g | r | s;

endmodule

// File: rtl/fp_norm_round.sv
// Post-add normalize (one left shift per cycle) and RNE round, FSM-sequenced with a valid/ready handshake.
module fp_norm_round
  import fp_norm_round_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_sign,
  input  logic [EXP_W-1:0]  in_exp,
  input  logic [MANT_W-1:0] in_mant,
  input  logic              in_carry,
  input  logic              in_g,
  input  logic              in_r,
  input  logic              in_s,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_sign,
  output logic [EXP_W-1:0]  out_exp,
  output logic [MANT_W-2:0] out_frac,
  output logic              flag_nx,
  output logic              flag_of,
  output logic              flag_uf
);

  localparam logic [EXP_W:0] EXP_ONE = (EXP_W+1)'(1);
  localparam logic [EXP_W:0] EXP_SAT = (EXP_W+1)'(EXP_MAX);

  state_e            r_state, w_state_nxt;
  logic              r_sign;
  logic [EXP_W:0]    r_exp;
  logic [MANT_W-1:0] r_mant;
  logic              r_g, r_r, r_s, r_sub;
  res_t              r_res, w_res;

  logic              w_acc_zero, w_norm_done;
  logic [MANT_W-1:0] w_mant_rnd;
  logic              w_ovf, w_inexact;
  logic [EXP_W:0]    w_exp_rnd, w_exp_enc;

  assign w_acc_zero  = ~in_carry & (in_mant == '0);
  assign w_norm_done = r_mant[MANT_W-1] | (r_exp <= EXP_ONE);

  fp_round_rne u_rne (
    .mant     (r_mant),
    .g        (r_g),
    .r        (r_r),
    .s        (r_s),
    .mant_rnd (w_mant_rnd),
    .mant_ovf (w_ovf),
    .inexact  (w_inexact)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (in_valid) w_state_nxt = w_acc_zero ? ST_DONE : ST_NORM;
      ST_NORM:  if (w_norm_done) w_state_nxt = ST_ROUND;
      ST_ROUND: w_state_nxt = ST_DONE;
      ST_DONE:  if (out_ready) w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (r_state == ST_IDLE);
    out_valid = (r_state == ST_DONE);
  end

  // A subnormal that rounds into bit 23 becomes the smallest normal.
  always_comb begin
    w_exp_rnd = r_exp + {{EXP_W{1'b0}}, w_ovf};
    w_exp_enc = r_sub ? {{EXP_W{1'b0}}, w_mant_rnd[MANT_W-1]} : w_exp_rnd;
    w_res      = '0;
    w_res.sign = r_sign;
    w_res.uf   = r_sub & w_inexact;
    if (w_exp_enc >= EXP_SAT) begin
      w_res.exp = EXP_W'(EXP_MAX);
      w_res.of  = 1'b1;
      w_res.nx  = 1'b1;
    end else begin
      w_res.exp  = w_exp_enc[EXP_W-1:0];
      w_res.frac = w_mant_rnd[MANT_W-2:0];
      w_res.nx   = w_inexact;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sign <= 1'b0;
      r_exp  <= '0;
      r_mant <= '0;
      r_g    <= 1'b0;
      r_r    <= 1'b0;
      r_s    <= 1'b0;
      r_sub  <= 1'b0;
      r_res  <= '0;
    end else begin
      case (r_state)
        ST_IDLE: if (in_valid) begin
          r_sign <= in_sign;
          r_sub  <= 1'b0;
          if (in_carry) begin
            r_mant <= {1'b1, in_mant[MANT_W-1:1]};
            r_exp  <= {1'b0, in_exp} + EXP_ONE;
            r_g    <= in_mant[0];
            r_r    <= in_g;
            r_s    <= in_r | in_s;
          end else begin
            r_mant <= in_mant;
            r_exp  <= {1'b0, in_exp};
            r_g    <= in_g;
            r_r    <= in_r;
            r_s    <= in_s;
          end
          if (w_acc_zero) r_res <= '0;
        end
        ST_NORM: if (!r_mant[MANT_W-1]) begin
          if (r_exp > EXP_ONE) begin
            r_mant <= {r_mant[MANT_W-2:0], r_g};
            r_g    <= r_r;
            r_r    <= 1'b0;
            r_exp  <= r_exp - EXP_ONE;
          end else begin
            r_sub  <= 1'b1;
          end
        end
        ST_ROUND: r_res <= w_res;
        default: ;
      endcase
    end
  end

  assign out_sign = r_res.sign;
  assign out_exp  = r_res.exp;
  assign out_frac = r_res.frac;
  assign flag_nx  = r_res.nx;
  assign flag_of  = r_res.of;
  assign flag_uf  = r_res.uf;

endmodule

// File: tb/tb_fp_norm_round.sv
// Random + directed check of fp_norm_round against an arithmetic normalize/round model.
module tb_fp_norm_round;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0, in_ready;
  logic        in_sign = 1'b0;
  logic [7:0]  in_exp = '0;
  logic [23:0] in_mant = '0;
  logic        in_carry = 1'b0, in_g = 1'b0, in_r = 1'b0, in_s = 1'b0;
  logic        out_valid, out_ready = 1'b0, out_sign;
  logic [7:0]  out_exp;
  logic [22:0] out_frac;
  logic        flag_nx, flag_of, flag_uf;

  int n_vec = 0, n_err = 0;
  logic        q_sign, q_nx, q_of, q_uf;
  logic [7:0]  q_exp;
  logic [22:0] q_frac;
  int          q_lat;

  fp_norm_round dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_sign(in_sign), .in_exp(in_exp), .in_mant(in_mant), .in_carry(in_carry),
    .in_g(in_g), .in_r(in_r), .in_s(in_s),
    .out_valid(out_valid), .out_ready(out_ready), .out_sign(out_sign),
    .out_exp(out_exp), .out_frac(out_frac),
    .flag_nx(flag_nx), .flag_of(flag_of), .flag_uf(flag_uf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s got=%0h want=%0h", tag, got, want);
    end
  endtask

  // Value-level model: shift count is min(leading zeros, exp-1), then RNE on the 24-bit window.
  task automatic model(input logic sg, input logic [7:0] e, input logic [23:0] m,
                       input logic c, input logic g, input logic r, input logic s,
                       output logic xs, output logic [7:0] xe, output logic [22:0] xf,
                       output logic xnx, output logic xof, output logic xuf, output int xlat);
    logic [23:0] mt;
    logic [25:0] ext;
    logic [24:0] val;
    logic        gg, rr, ss, sub, inc;
    int          ex, n, msb, lim, enc;
    xs = 1'b0; xe = '0; xf = '0; xnx = 1'b0; xof = 1'b0; xuf = 1'b0; xlat = 1;
    if (!c && m == 24'd0) return;
    if (c) begin
      mt = {1'b1, m[23:1]}; ex = int'(e) + 1; gg = m[0]; rr = g; ss = r | s;
    end else begin
      mt = m; ex = int'(e); gg = g; rr = r; ss = s;
    end
    msb = 0;
    for (int i = 0; i < 24; i++) if (mt[i]) msb = i;
    lim = (ex > 1) ? ex - 1 : 0;
    n = 23 - msb;
    if (n > lim) n = lim;
    ext = {mt, gg, rr} << n;
    ex  = ex - n;
    sub = !ext[25];
    gg  = ext[1];
    rr  = ext[0];
    inc = gg & (rr | ss | ext[2]);
    val = {1'b0, ext[25:2]} + {24'd0, inc};
    if (val[24]) begin val = 25'h0800000; ex++; end
    xnx = gg | rr | ss;
    xuf = sub & xnx;
    enc = sub ? (val[23] ? 1 : 0) : ex;
    xs  = sg;
    if (enc >= 255) begin
      xe = 8'hFF; xof = 1'b1; xnx = 1'b1;
    end else begin
      xe = 8'(enc); xf = val[22:0];
    end
    xlat = 3 + n;
  endtask

  task automatic run_op(input string tag, input logic sg, input logic [7:0] e, input logic [23:0] m,
                        input logic c, input logic g, input logic r, input logic s, input int hold);
    logic        xs, xnx, xof, xuf;
    logic [7:0]  xe;
    logic [22:0] xf;
    int          xlat;
    logic        same;
    model(sg, e, m, c, g, r, s, xs, xe, xf, xnx, xof, xuf, xlat);
    @(negedge clk);
    in_sign = sg; in_exp = e; in_mant = m; in_carry = c;
    in_g = g; in_r = r; in_s = s; in_valid = 1'b1;
    chk({tag, "_rdy"}, 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    q_lat = 1;
    while (!out_valid && q_lat < 64) begin
      @(posedge clk); #1;
      q_lat++;
    end
    q_sign = out_sign; q_exp = out_exp; q_frac = out_frac;
    q_nx = flag_nx; q_of = flag_of; q_uf = flag_uf;
    chk({tag, "_lat"},  32'(q_lat), 32'(xlat));
    chk({tag, "_sign"}, 32'(q_sign), 32'(xs));
    chk({tag, "_exp"},  32'(q_exp), 32'(xe));
    chk({tag, "_frac"}, 32'(q_frac), 32'(xf));
    chk({tag, "_flg"},  {29'd0, q_nx, q_of, q_uf}, {29'd0, xnx, xof, xuf});
    for (int k = 0; k < hold; k++) begin
      @(posedge clk); #1;
      same = out_valid && !in_ready && out_exp == q_exp && out_frac == q_frac &&
             out_sign == q_sign && {flag_nx, flag_of, flag_uf} == {q_nx, q_of, q_uf};
      chk({tag, "_hold"}, 32'(same), 32'd1);
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({tag, "_ret"}, {30'd0, out_valid, in_ready}, 32'b01);
  endtask

  initial begin
    logic [23:0] m;
    logic [7:0]  e;
    logic        bad;
    #12;
    chk("rst_vld",  {30'd0, out_valid, in_ready}, 32'b01);
    chk("rst_outs", {out_sign, out_exp, out_frac}, 32'd0);
    chk("rst_flg",  {29'd0, flag_nx, flag_of, flag_uf}, 32'd0);
    @(negedge clk); rst_n = 1'b1;

    run_op("carry3", 1'b0, 8'd127, 24'h800000, 1'b1, 1'b0, 1'b0, 1'b0, 0);
    chk("carry3_exp_k", 32'(q_exp), 32'd128);
    chk("carry3_frac_k", 32'(q_frac), 32'h400000);
    chk("carry3_lat_k", 32'(q_lat), 32'd3);
    run_op("cancel", 1'b0, 8'd127, 24'h000001, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    chk("cancel_exp_k", 32'(q_exp), 32'd104);
    chk("cancel_lat_k", 32'(q_lat), 32'd26);
    run_op("tie_odd", 1'b0, 8'd127, 24'h800001, 1'b0, 1'b1, 1'b0, 1'b0, 0);
    chk("tie_odd_k", {8'd0, q_nx, q_frac}, {8'd0, 1'b1, 23'h000002});
    run_op("tie_even", 1'b1, 8'd127, 24'h800000, 1'b0, 1'b1, 1'b0, 1'b0, 0);
    chk("tie_even_k", {8'd0, q_nx, q_frac}, {8'd0, 1'b1, 23'h000000});
    run_op("rnd_ovf", 1'b0, 8'd127, 24'hFFFFFF, 1'b0, 1'b1, 1'b1, 1'b0, 0);
    chk("rnd_ovf_k", {1'b0, q_exp, q_frac}, {1'b0, 8'd128, 23'd0});
    run_op("exp_ovf", 1'b0, 8'd254, 24'h800000, 1'b1, 1'b0, 1'b0, 1'b0, 0);
    chk("exp_ovf_k", {q_of, q_nx, q_exp, q_frac}, {1'b1, 1'b1, 8'd255, 23'd0});
    run_op("zero", 1'b1, 8'd90, 24'd0, 1'b0, 1'b1, 1'b1, 1'b1, 0);
    chk("zero_k", {q_sign, q_exp, q_nx, q_of, q_uf, 5'd0, q_lat[3:0]}, 32'd1);
    run_op("subn", 1'b0, 8'd2, 24'h200000, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    chk("subn_k", {q_uf, q_exp, q_frac}, {1'b0, 8'd0, 23'h400000});
    run_op("hold5", 1'b0, 8'd100, 24'h123457, 1'b1, 1'b1, 1'b0, 1'b1, 5);

    // Abort a long normalization with reset; no result may appear afterwards.
    @(negedge clk);
    in_exp = 8'd127; in_mant = 24'h000001; in_carry = 1'b0;
    in_g = 1'b0; in_r = 1'b0; in_s = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1 rst_n = 1'b0;
    #1 chk("midrst_vld", {30'd0, out_valid, in_ready}, 32'b01);
    @(negedge clk) rst_n = 1'b1;
    bad = 1'b0;
    repeat (40) begin @(posedge clk); #1 if (out_valid || !in_ready) bad = 1'b1; end
    chk("midrst_quiet", 32'(bad), 32'd0);
    run_op("post_rst", 1'b0, 8'd127, 24'h400000, 1'b0, 1'b0, 1'b1, 1'b0, 0);

    for (int t = 0; t < 250; t++) begin
      m = 24'($urandom);
      case ($urandom_range(0, 3))
        0: ;
        1: m = m >> $urandom_range(0, 23);
        2: m = (t % 3 == 0) ? 24'd0 : 24'($urandom_range(1, 7));
        default: m[23] = 1'b1;
      endcase
      e = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 24)) : 8'($urandom_range(1, 254));
      run_op("rand", 1'($urandom), e, m, 1'($urandom), 1'($urandom), 1'($urandom),
             1'($urandom), (t % 50 == 7) ? 2 : 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
